// File: rtl/time_date_counter.sv
// Seconds-through-years timekeeping register file (century 2000-2099).
// It advances on the 1 Hz strobe in run mode and takes single-step field edits in set mode.
module time_date_counter #(
    parameter int RST_YEAR  = 0,
    parameter int RST_MONTH = 1,
    parameter int RST_DAY   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       run,
    input  logic       up_s,
    input  logic       down_s,
    input  logic       up_m,
    input  logic       down_m,
    input  logic       up_h,
    input  logic       down_h,
    input  logic       up_d,
    input  logic       down_d,
    input  logic       up_mo,
    input  logic       down_mo,
    input  logic       up_y,
    input  logic       down_y,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic       century_wrap
);

    logic [5:0]  r_sec, r_min;
    logic [4:0]  r_hour, r_day;
    logic [3:0]  r_month;
    logic [6:0]  r_year;
    logic        r_cw;
    logic [11:0] r_prev;

    logic [5:0]  w_sec_n, w_min_n;
    logic [4:0]  w_hour_n, w_day_n;
    logic [3:0]  w_month_n;
    logic [6:0]  w_year_n;
    logic        w_cw_n;
    logic [11:0] w_adj, w_edge;
    logic [5:0]  w_up, w_dn;
    logic        w_found;
    logic [4:0]  w_dim;

    function automatic logic [4:0] f_dim(input logic [3:0] mo, input logic [6:0] yr);
        case (mo)
            4'd4, 4'd6, 4'd9, 4'd11: f_dim = 5'd30;
            4'd2:                    f_dim = (yr[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 f_dim = 5'd31;
        endcase
    endfunction

    // Range-wrapping steps; the >=/> forms pull a forced out-of-range value back into range.
    function automatic logic [6:0] f_up(input logic [6:0] v, input logic [6:0] lo,
                                        input logic [6:0] hi);
        f_up = (v >= hi) ? lo : v + 7'd1;
    endfunction

    function automatic logic [6:0] f_dn(input logic [6:0] v, input logic [6:0] lo,
                                        input logic [6:0] hi);
        f_dn = (v <= lo || v > hi) ? hi : v - 7'd1;
    endfunction

    // Field f owns bits {down, up} at [2f+1 : 2f], f=0 is seconds (highest priority).
    assign w_adj  = {down_y, up_y, down_mo, up_mo, down_d, up_d,
                     down_h, up_h, down_m, up_m, down_s, up_s};
    assign w_edge = w_adj & ~r_prev;
    assign w_dim  = f_dim(r_month, r_year);

    always_comb begin
        w_up    = '0;
        w_dn    = '0;
        w_found = 1'b0;
        for (int f = 0; f < 6; f++) begin
            if (!w_found && (w_edge[2*f] || w_edge[2*f+1])) begin
                w_found = 1'b1;
                w_up[f] = w_edge[2*f] & ~w_edge[2*f+1];
                w_dn[f] = w_edge[2*f+1] & ~w_edge[2*f];
            end
        end
    end

    always_comb begin
        w_sec_n   = r_sec;
        w_min_n   = r_min;
        w_hour_n  = r_hour;
        w_day_n   = r_day;
        w_month_n = r_month;
        w_year_n  = r_year;
        w_cw_n    = 1'b0;
        if (run) begin
            if (tick_1hz) begin
                w_sec_n = 6'(f_up(7'(r_sec), 7'd0, 7'd59));
                if (r_sec >= 6'd59) begin
                    w_min_n = 6'(f_up(7'(r_min), 7'd0, 7'd59));
                    if (r_min >= 6'd59) begin
                        w_hour_n = 5'(f_up(7'(r_hour), 7'd0, 7'd23));
                        if (r_hour >= 5'd23) begin
                            w_day_n = 5'(f_up(7'(r_day), 7'd1, 7'(w_dim)));
                            if (r_day >= w_dim) begin
                                w_month_n = 4'(f_up(7'(r_month), 7'd1, 7'd12));
                                if (r_month >= 4'd12) begin
                                    w_year_n = f_up(r_year, 7'd0, 7'd99);
                                    w_cw_n   = (r_year >= 7'd99);
                                end
                            end
                        end
                    end
                end
            end
        end else begin
            if (w_up[0]) w_sec_n = 6'(f_up(7'(r_sec), 7'd0, 7'd59));
            if (w_dn[0]) w_sec_n = 6'(f_dn(7'(r_sec), 7'd0, 7'd59));
            if (w_up[1]) w_min_n = 6'(f_up(7'(r_min), 7'd0, 7'd59));
            if (w_dn[1]) w_min_n = 6'(f_dn(7'(r_min), 7'd0, 7'd59));
            if (w_up[2]) w_hour_n = 5'(f_up(7'(r_hour), 7'd0, 7'd23));
            if (w_dn[2]) w_hour_n = 5'(f_dn(7'(r_hour), 7'd0, 7'd23));
            if (w_up[3]) w_day_n = 5'(f_up(7'(r_day), 7'd1, 7'(w_dim)));
            if (w_dn[3]) w_day_n = 5'(f_dn(7'(r_day), 7'd1, 7'(w_dim)));
            if (w_up[4]) w_month_n = 4'(f_up(7'(r_month), 7'd1, 7'd12));
            if (w_dn[4]) w_month_n = 4'(f_dn(7'(r_month), 7'd1, 7'd12));
            if (w_up[5]) w_year_n = f_up(r_year, 7'd0, 7'd99);
            if (w_dn[5]) w_year_n = f_dn(r_year, 7'd0, 7'd99);
            // A shorter new month (or a non-leap February) pulls the day down to its last day.
            if ((w_up[5:4] != 2'b00) || (w_dn[5:4] != 2'b00)) begin
                if (r_day > f_dim(w_month_n, w_year_n))
                    w_day_n = f_dim(w_month_n, w_year_n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec   <= '0;
            r_min   <= '0;
            r_hour  <= '0;
            r_day   <= 5'(RST_DAY);
            r_month <= 4'(RST_MONTH);
            r_year  <= 7'(RST_YEAR);
            r_cw    <= 1'b0;
            r_prev  <= '0;
        end else begin
            r_sec   <= w_sec_n;
            r_min   <= w_min_n;
            r_hour  <= w_hour_n;
            r_day   <= w_day_n;
            r_month <= w_month_n;
            r_year  <= w_year_n;
            r_cw    <= w_cw_n;
            r_prev  <= w_adj;
        end
    end

    assign sec          = r_sec;
    assign min          = r_min;
    assign hour         = r_hour;
    assign day          = r_day;
    assign month        = r_month;
    assign year         = r_year;
    assign century_wrap = r_cw;

endmodule

// File: tb/tb_time_date_counter.sv
// Bench for time_date_counter: a cycle-level reference model pushes the expected state into a queue,
// which is compared every cycle, alongside directed checks of the calendar corner cases.
module tb_time_date_counter;

    localparam int US = 0, DS = 1, UM = 2, DM = 3, UH = 4, DH = 5;
    localparam int UD = 6, DD = 7, UMO = 8, DMO = 9, UY = 10, DY = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_1hz = 1'b0;
    logic        run = 1'b0;
    logic [11:0] adj = '0;
    logic [5:0]  sec, min;
    logic [4:0]  hour, day;
    logic [3:0]  month;
    logic [6:0]  year;
    logic        century_wrap;
    logic [33:0] dut_pk;

    int checks = 0;
    int failures = 0;

    logic [33:0] sb_q[$];
    int          m_sec, m_min, m_hour, m_day, m_mon, m_year, m_dir, m_sel, m_d;
    logic        m_cw;
    logic [11:0] m_prev, m_e;

    always #5 clk = ~clk;

    time_date_counter #(.RST_YEAR(23), .RST_MONTH(1), .RST_DAY(1)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .run(run),
        .up_s(adj[US]), .down_s(adj[DS]), .up_m(adj[UM]), .down_m(adj[DM]),
        .up_h(adj[UH]), .down_h(adj[DH]), .up_d(adj[UD]), .down_d(adj[DD]),
        .up_mo(adj[UMO]), .down_mo(adj[DMO]), .up_y(adj[UY]), .down_y(adj[DY]),
        .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year),
        .century_wrap(century_wrap)
    );

    assign dut_pk = {century_wrap, year, month, day, hour, min, sec};

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic int dim(input int mo, input int y);
        case (mo)
            4, 6, 9, 11: return 30;
            2:           return (y % 4 == 0) ? 29 : 28;
            default:     return 31;
        endcase
    endfunction

    function automatic logic [33:0] pk(input bit cw, input int y, input int mo, input int d,
                                       input int h, input int mi, input int s);
        return {cw, 7'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
    endfunction

    // Reference model: evaluates each posedge from the same inputs the DUT sees.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_year = 23;
                m_cw = 1'b0; m_prev = '0;
            end else begin
                m_e = adj & ~m_prev;
                m_prev = adj;
                m_cw = 1'b0;
                if (run) begin
                    if (tick_1hz) begin
                        m_sec++;
                        if (m_sec == 60) begin
                            m_sec = 0; m_min++;
                            if (m_min == 60) begin
                                m_min = 0; m_hour++;
                                if (m_hour == 24) begin
                                    m_hour = 0; m_day++;
                                    if (m_day > dim(m_mon, m_year)) begin
                                        m_day = 1; m_mon++;
                                        if (m_mon == 13) begin
                                            m_mon = 1; m_year++;
                                            if (m_year == 100) begin
                                                m_year = 0; m_cw = 1'b1;
                                            end
                                        end
                                    end
                                end
                            end
                        end
                    end
                end else begin
                    m_sel = -1;
                    for (int i = 0; i < 6; i++)
                        if (m_sel < 0 && (m_e[2*i] || m_e[2*i+1])) m_sel = i;
                    if (m_sel >= 0 && (m_e[2*m_sel] != m_e[2*m_sel+1])) begin
                        m_dir = m_e[2*m_sel] ? 1 : -1;
                        case (m_sel)
                            0: m_sec  = (m_sec + m_dir + 60) % 60;
                            1: m_min  = (m_min + m_dir + 60) % 60;
                            2: m_hour = (m_hour + m_dir + 24) % 24;
                            3: begin
                                m_d = dim(m_mon, m_year);
                                m_day = ((m_day - 1 + m_dir + m_d) % m_d) + 1;
                            end
                            4: m_mon  = ((m_mon - 1 + m_dir + 12) % 12) + 1;
                            default: m_year = (m_year + m_dir + 100) % 100;
                        endcase
                        if (m_sel >= 4 && m_day > dim(m_mon, m_year)) m_day = dim(m_mon, m_year);
                    end
                end
            end
            sb_q.push_back(pk(m_cw, m_year, m_mon, m_day, m_hour, m_min, m_sec));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) chk("scoreboard", dut_pk, sb_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse(input int idx);
        adj[idx] = 1'b1;
        cyc();
        adj[idx] = 1'b0;
        cyc();
    endtask

    task automatic pulse_n(input int idx, input int n);
        for (int i = 0; i < n; i++) pulse(idx);
    endtask

    task automatic tick_once();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        cyc();
    endtask

    task automatic to_235959();
        run = 1'b0;
        pulse(DS); pulse(DM); pulse(DH);
    endtask

    initial begin
        cyc(); cyc();
        chk("reset_state", dut_pk, pk(0, 23, 1, 1, 0, 0, 0));
        // Input already high as reset releases counts as a fresh edge.
        adj[US] = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("edge_after_reset", 34'(sec), 34'd1);
        adj[US] = 1'b0;
        cyc();
        pulse(DS);

        run = 1'b1;
        tick_1hz = 1'b1;
        cyc();
        chk("tick_latency", 34'(sec), 34'd1);
        tick_1hz = 1'b0;
        cyc();
        for (int i = 0; i < 59; i++) tick_once();
        chk("sixty_ticks", dut_pk, pk(0, 23, 1, 1, 0, 1, 0));

        run = 1'b0;
        pulse(DM); pulse(DS); pulse(DM); pulse(DH);
        pulse(DMO); pulse(DD);
        pulse_n(DY, 24);
        chk("preload", dut_pk, pk(0, 99, 12, 31, 23, 59, 59));
        run = 1'b1;
        tick_1hz = 1'b1;
        cyc();
        chk("century_rollover", dut_pk, pk(1, 0, 1, 1, 0, 0, 0));
        tick_1hz = 1'b0;
        cyc();
        chk("century_wrap_one_clk", 34'(century_wrap), 34'd0);

        run = 1'b0;
        pulse_n(UY, 24); pulse(UMO); pulse(DD);
        chk("leap_feb_down_day", 34'(day), 34'd29);
        pulse(DD);
        to_235959();
        run = 1'b1;
        tick_once();
        chk("leap_feb28_to_29", dut_pk, pk(0, 24, 2, 29, 0, 0, 0));
        to_235959();
        run = 1'b1;
        tick_once();
        chk("leap_feb29_to_mar1", dut_pk, pk(0, 24, 3, 1, 0, 0, 0));
        run = 1'b0;
        pulse(DY); pulse(DMO); pulse(DD);
        to_235959();
        run = 1'b1;
        tick_once();
        chk("nonleap_feb28_to_mar1", dut_pk, pk(0, 23, 3, 1, 0, 0, 0));

        run = 1'b0;
        tick_1hz = 1'b1;
        adj[UM] = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        adj[UM] = 1'b0;
        cyc();
        chk("held_up_m_single_step", dut_pk, pk(0, 23, 3, 1, 0, 1, 0));
        pulse(DS);
        chk("down_s_wrap", dut_pk, pk(0, 23, 3, 1, 0, 1, 59));
        tick_1hz = 1'b0;

        pulse(DD);
        chk("down_d_wrap", 34'(day), 34'd31);
        pulse(DMO);
        chk("clamp_nonleap", dut_pk, pk(0, 23, 2, 28, 0, 1, 59));
        pulse(UMO); pulse_n(UD, 3); pulse(UY); pulse(DMO);
        chk("clamp_leap", dut_pk, pk(0, 24, 2, 29, 0, 1, 59));

        adj[UH] = 1'b1; adj[UD] = 1'b1;
        cyc();
        adj = '0;
        cyc();
        chk("priority_hour_over_day", dut_pk, pk(0, 24, 2, 29, 1, 1, 59));
        adj[UY] = 1'b1; adj[DY] = 1'b1;
        cyc();
        adj = '0;
        cyc();
        chk("up_down_cancel", 34'(year), 34'd24);
        run = 1'b1;
        adj[US] = 1'b1;
        cyc(); cyc();
        run = 1'b0;
        cyc(); cyc();
        chk("held_through_run_fall", 34'(sec), 34'd59);
        adj = '0;
        cyc();
        run = 1'b1; tick_1hz = 1'b1; rst = 1'b1;
        cyc();
        chk("reset_beats_tick", dut_pk, pk(0, 23, 1, 1, 0, 0, 0));
        rst = 1'b0; tick_1hz = 1'b0;
        cyc();

        for (int i = 0; i < 400; i++) begin
            run = ($urandom_range(0, 3) == 0);
            tick_1hz = $urandom_range(0, 1) != 0;
            adj = 12'($urandom) & 12'($urandom);
            cyc();
        end
        adj = '0; run = 1'b0; tick_1hz = 1'b0;
        cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_date_counter.md
Name: time_date_counter

Overview:
- Timekeeping datapath directly downstream of the set-mode control FSM.
- Counts seconds through years (00-99, century 2000-2099) from a 1 Hz strobe while running.
- In set mode, applies the FSM's per-field up/down requests as single steps.
- Feeds the display/blink path with binary field values.

Parameters:
- RST_YEAR, 0, year value loaded at reset (0-99).
- RST_MONTH, 1, month loaded at reset (1-12).
- RST_DAY, 1, day loaded at reset (1-28).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- tick_1hz  input  1  one-clk strobe, once per second.
- run  input  1  1 = timekeeping; 0 = set mode. Same polarity as the FSM's en input.
- up_s, down_s  input  1 each  second adjust level.
- up_m, down_m  input  1 each  minute adjust level.
- up_h, down_h  input  1 each  hour adjust level.
- up_d, down_d  input  1 each  day adjust level.
- up_mo, down_mo  input  1 each  month adjust level.
- up_y, down_y  input  1 each  year adjust level.
- sec  output  6  0-59.
- min  output  6  0-59.
- hour  output  5  0-23.
- day  output  5  1-28/29/30/31.
- month  output  4  1-12.
- year  output  7  0-99.
- century_wrap  output  1  one-clk pulse when year wraps 99->0 via tick carry.

Behaviour:
- Single clock domain. Every output register updates only on posedge clk.
- Reset (rst=1 at posedge):
  - sec=min=hour=0; day=RST_DAY; month=RST_MONTH; year=RST_YEAR.
  - century_wrap=0. All 12 adjust edge-detect registers cleared to 0.
  - Reset overrides tick and adjust in the same cycle.
- Edge detection:
  - Each of the 12 adjust inputs has a previous-value register, updated every non-reset cycle regardless of run.
  - A rising edge = input 1 and previous 0.
  - A level held across a run 1->0 transition produces no step.
  - An input already high in the first cycle after reset counts as an edge.
- days_in_month:
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - February: 29 if year[1:0]==0, else 28. Year 0 (2000) is leap.
- Run mode (run=1):
  - Adjust edges are ignored (registers still track).
  - On a cycle with tick_1hz=1, fields update next edge (latency 1 clk) with full carry chain.
  - sec 59->0 carries to min.
  - min 59->0 carries to hour.
  - hour 23->0 carries to day.
  - day == days_in_month -> 1 carries to month.
  - month 12->1 carries to year.
  - year 99->0 asserts century_wrap for exactly that one cycle.
  - All carries resolve in the same cycle. Example: 99-12-31 23:59:59 -> 00-01-01 00:00:00 in one step.
- Set mode (run=0):
  - tick_1hz is ignored; time is frozen.
  - A rising edge on up_x/down_x steps field x by +1/-1 next cycle.
  - No carry into other fields.
  - Wrap within range: sec/min 59<->0, hour 23<->0, month 12<->1, year 99<->0, day days_in_month<->1.
  - up and down edges on the same field in the same cycle: no change.
  - Edges on multiple fields in the same cycle: only the highest-priority field steps (sec>min>hour>day>month>year); other edges are discarded, not queued.
- Day clamp:
  - After any month or year step (set mode) that makes day > new days_in_month, day becomes days_in_month in the same update.
  - Example: 03-31 down_mo -> 02-28 in a non-leap year.
- century_wrap is never asserted by a set-mode year wrap.
- Out-of-range states are unreachable. If forced, the next tick or adjust still applies the wrap rules using ">=" comparisons.

Test Plan:
1. Reset with RST_YEAR=23, then run=1 and 60 ticks from 00:00:00 -> min=1, sec=0, other fields unchanged; each field changes exactly one clk after its tick.
2. Preload 99-12-31 23:59:59, run=1, one tick -> year=0, month=1, day=1, all time fields 0; century_wrap high for exactly 1 clk.
3. year=24 (leap), month=2, day=28: tick at 23:59:59 -> day=29. At 02-29 23:59:59 another tick -> month=3, day=1. Repeat with year=23 -> 02-28 rolls to 03-01.
4. run=0, hold up_m high for 5 clks -> min +1 only. Pulse down_s at sec=0 -> sec=59, min unchanged. Assert tick_1hz throughout -> no time advance.
5. run=0, day=31 month=3 year=23, pulse down_mo -> month=2, day=28. With year=24, same stimulus -> day=29.
6. run=0, up_h and up_d rising in the same cycle -> only hour steps. up_y and down_y together -> year unchanged. Hold up_s through run 1->0 -> no step. rst during a run tick -> reset values win.
